aes_multikey_encrypt: RTL and testbench

AES_MULTIKEY_ENCRYPT -- requirements
Module: aes_multikey_encrypt

---
 rtl/aes_multikey_encrypt.sv | 179 +++++++++++++++++
 tb/tb_aes_multikey_encrypt.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_multikey_encrypt.sv
// Iterative AES encryptor for 128/192/256-bit keys: one key-expansion word or one
// cipher round per clock, with a 60-word round-key store shared by all key lengths.
module aes_multikey_encrypt #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         key_ok,
    output logic         key_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

    state_t       state;
    logic [3:0]   nk, nr, rnd, nk_new, nr_new;
    logic [5:0]   widx;
    logic [2:0]   kmod;
    logic [7:0]   rcon;
    logic [31:0]  w [0:59];
    logic [127:0] st, round_key, round_out;
    logic [31:0]  prev_word, temp_word;
    logic         len_bad, key_acc, blk_acc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y, b;
        y = x;
        for (int i = 0; i < 6; i++) y = gf_mul(gf_mul(y, y), x);
        b = gf_mul(y, y);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] sb, sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int n = 0; n < 16; n++) sb[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return (last ? sr : mc) ^ rk;
    endfunction

    always_comb begin
        nk_new = 4'd4;
        nr_new = 4'd10;
        case (key_len)
            2'b01:   begin nk_new = 4'd6; nr_new = 4'd12; end
            2'b10:   begin nk_new = 4'd8; nr_new = 4'd14; end
            default: ;
        endcase
        len_bad = (key_len == 2'b11) || (key_len == 2'b01 && MAX_KEY_BITS < 192) ||
                  (key_len == 2'b10 && MAX_KEY_BITS < 256);
    end

    // Key load takes priority over a block in the same IDLE cycle
    assign key_ready = (state == IDLE);
    assign in_ready  = (state == IDLE) && key_ok && !key_valid;
    assign key_acc   = key_ready && key_valid;
    assign blk_acc   = in_ready && in_valid;

    always_comb begin
        prev_word = w[widx - 6'd1];
        temp_word = prev_word;
        if (kmod == 3'd0)
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
        else if (nk == 4'd8 && kmod == 3'd4)
            temp_word = sub_word(prev_word);
        round_key = {w[{rnd, 2'b00}], w[{rnd, 2'b01}], w[{rnd, 2'b10}], w[{rnd, 2'b11}]};
        round_out = aes_round(st, round_key, rnd == nr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_ok    <= 1'b0;
            key_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            rnd       <= 4'd0;
        end else begin
            key_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_acc) begin
                        key_ok <= 1'b0;
                        if (len_bad) key_err <= 1'b1;
                        else         state   <= KEXP;
                    end else if (blk_acc) begin
                        state <= ROUND;
                        rnd   <= 4'd1;
                    end
                end
                KEXP: begin
                    if (widx == {nr, 2'b11}) begin
                        key_ok <= 1'b1;
                        state  <= IDLE;
                    end
                end
                ROUND: begin
                    if (rnd == nr) begin
                        out_data  <= round_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath and round-key store carry no reset; they are always rewritten before use
    always_ff @(posedge clk) begin
        if (key_acc && !len_bad) begin
            nk   <= nk_new;
            nr   <= nr_new;
            widx <= {2'b00, nk_new};
            kmod <= 3'd0;
            rcon <= 8'h01;
            for (int k = 0; k < 8; k++)
                if (k < int'(nk_new)) w[k] <= key[255-32*k -: 32];
        end else if (state == KEXP) begin
            w[widx] <= w[widx - {2'b00, nk}] ^ temp_word;
            widx    <= widx + 6'd1;
            kmod    <= ({1'b0, kmod} == nk - 4'd1) ? 3'd0 : kmod + 3'd1;
            if (kmod == 3'd0) rcon <= xtime(rcon);
        end
        if (blk_acc)
            st <= in_data ^ {w[0], w[1], w[2], w[3]};
        else if (state == ROUND)
            st <= round_out;
    end
endmodule

// File: tb/tb_aes_multikey_encrypt.sv
// Self-checking bench: FIPS-197 known answers plus random keys/blocks against a
// byte-level AES reference model, including backpressure, key errors and mid-block reset.
module tb_aes_multikey_encrypt;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0, key_valid2 = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key = '0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [127:0] in_data = '0;
    logic         key_ready, key_ok, key_err, in_ready, out_valid;
    logic [127:0] out_data;
    logic         key_ready2, key_ok2, key_err2, in_ready2, out_valid2;
    logic [127:0] out_data2;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;

    aes_multikey_encrypt #(.MAX_KEY_BITS(256)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key_len(key_len),
        .key(key), .key_ok(key_ok), .key_err(key_err), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

    aes_multikey_encrypt #(.MAX_KEY_BITS(128)) dut2 (
        .clk(clk), .rst(rst), .key_valid(key_valid2), .key_ready(key_ready2), .key_len(key_len),
        .key(key), .key_ok(key_ok2), .key_err(key_err2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        int p, x, y;
        p = 0; x = int'(a); y = int'(b);
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
            y = y >> 1;
        end
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_subw(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [255:0] k, input logic [1:0] len,
                                                 input logic [127:0] pt);
        int nk, nr;
        logic [31:0]  wk [60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   a [4];
        logic [127:0] ct;
        nk = 4 + 2 * int'(len);
        nr = nk + 6;
        for (int i = 0; i < nk; i++) wk[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = wk[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = m_mul(rc, 8'h02);
                t = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = m_subw(t);
            end
            wk[i] = wk[i-nk] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ wk[c][31-8*r -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) tmp[r][c] = sbox_t[s[r][c]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = tmp[r][(c+r)%4];
            if (rd < nr)
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[r][c];
                    for (int r = 0; r < 4; r++)
                        s[r][c] = m_mul(8'h02, a[r]) ^ m_mul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ wk[4*rd+c][31-8*r -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) ct[127-8*(4*c+r) -: 8] = s[r][c];
        return ct;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_key(input logic [1:0] len, input logic [255:0] k, input int exp_cyc,
                            input string tag);
        int n;
        check({tag, "_key_ready"}, 128'(key_ready), 128'(1));
        key_valid = 1'b1; key_len = len; key = k;
        @(negedge clk);
        key_valid = 1'b0; key = rand256();
        check({tag, "_key_ok_cleared"}, 128'(key_ok), 128'(0));
        n = 0;
        while (!key_ok && n < 100) begin @(negedge clk); n++; end
        check({tag, "_kexp_cycles"}, 128'(n), 128'(exp_cyc));
    endtask

    task automatic do_block(input logic [127:0] pt, input logic [127:0] exp, input int nr,
                            input int hold, input string tag);
        int n;
        logic [127:0] ct;
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1; in_data = pt;
        @(negedge clk);
        in_valid = 1'b0; in_data = rand256()[127:0];
        n = 0;
        while (!out_valid && n < 64) begin @(negedge clk); n++; end
        check({tag, "_latency"}, 128'(n), 128'(nr));
        check({tag, "_out_data"}, out_data, exp);
        ct = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_data"}, out_data, ct);
            check({tag, "_hold_in_ready"}, 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 128'(out_valid), 128'(0));
        check({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [255:0] k256, kr;
        logic [127:0] pt, rb;
        logic [1:0]   len;
        int n;
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pt   = 128'h00112233445566778899aabbccddeeff;
        build_sbox();

        repeat (3) @(negedge clk);
        check("rst_key_ok", 128'(key_ok), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_key_err", 128'(key_err), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_key_ready", 128'(key_ready), 128'(1));
        check("post_rst_in_ready", 128'(in_ready), 128'(0));

        kr = rand256();
        load_key(2'b00, {k256[255:128], kr[127:0]}, 40, "kat128");
        do_block(pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 20, "kat128");
        load_key(2'b01, {k256[255:64], kr[63:0]}, 46, "kat192");
        do_block(pt, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12, 0, "kat192");
        load_key(2'b10, k256, 52, "kat256");
        do_block(pt, 128'h8ea2b7ca516745bfeafc49904b496089, 14, 0, "kat256");

        key_valid = 1'b1; key_len = 2'b11; key = rand256();
        @(negedge clk);
        key_valid = 1'b0;
        check("bad_len_key_err", 128'(key_err), 128'(1));
        check("bad_len_key_ok", 128'(key_ok), 128'(0));
        check("bad_len_idle", 128'(key_ready), 128'(1));
        in_valid = 1'b1;
        @(negedge clk);
        check("bad_len_err_pulse", 128'(key_err), 128'(0));
        check("bad_len_in_ready", 128'(in_ready), 128'(0));
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("bad_len_no_block", 128'(out_valid), 128'(0));

        key_valid2 = 1'b1; key_len = 2'b00; key = k256;
        @(negedge clk);
        key_valid2 = 1'b0;
        n = 0;
        while (!key_ok2 && n < 100) begin @(negedge clk); n++; end
        check("max128_kexp_cycles", 128'(n), 128'(40));
        key_valid2 = 1'b1; key_len = 2'b10;
        @(negedge clk);
        key_valid2 = 1'b0;
        check("max128_key_err", 128'(key_err2), 128'(1));
        check("max128_key_ok", 128'(key_ok2), 128'(0));
        @(negedge clk);
        check("max128_err_pulse", 128'(key_err2), 128'(0));
        check("max128_in_ready", 128'(in_ready2), 128'(0));

        for (int it = 0; it < 6; it++) begin
            len = 2'($urandom_range(0, 2));
            kr  = rand256();
            load_key(len, kr, 4 * (11 + 2 * int'(len)) - (4 + 2 * int'(len)), "rnd");
            for (int b = 0; b < 2; b++) begin
                rb = rand256()[127:0];
                do_block(rb, ref_encrypt(kr, len, rb), 10 + 2 * int'(len),
                         int'($urandom_range(0, 3)), "rnd");
            end
        end

        kr = rand256();
        key_valid = 1'b1; key_len = 2'b00; key = {k256[255:128], kr[127:0]};
        in_valid = 1'b1; in_data = pt;
        #1;
        check("prio_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        key_valid = 1'b0; in_valid = 1'b0;
        check("prio_key_ok_cleared", 128'(key_ok), 128'(0));
        n = 0;
        while (!key_ok && n < 100) begin @(negedge clk); n++; end
        check("prio_kexp_cycles", 128'(n), 128'(40));
        check("prio_no_block", 128'(out_valid), 128'(0));
        do_block(pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 0, "prio");

        in_valid = 1'b1; in_data = pt;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_key_ok", 128'(key_ok), 128'(0));
        check("midrst_out_data", out_data, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_after_key_ok", 128'(key_ok), 128'(0));
        check("midrst_after_in_ready", 128'(in_ready), 128'(0));
        check("midrst_after_out_valid", 128'(out_valid), 128'(0));
        load_key(2'b00, {k256[255:128], 128'h0}, 40, "reload");
        do_block(pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 0, "reload");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
